seq_frame_tx: RTL and testbench

Serial frame transmitter. It is the sending end of the sync-pattern detection link: it emits the 4-bit sync marker 1110 on a 1-bit line, then a DATA_W-bit payload, MSB first. Zero-insertion (bit stuffing) in the payload keeps a downstream 1110 sequence detector from ever firing inside the payload. The line idles at 0.

---
 rtl/seq_link_pkg.sv | 15 +
 rtl/seq_frame_tx.sv | 139 +++++++++++++
 tb/tb_seq_frame_tx.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_link_pkg.sv
// Shared constants for the 1110-sync serial link: FSM encoding, sync marker
// and stuffing run limit. Used by both the transmitter and the receive side.
package seq_link_pkg;

  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] SYNC  = 2'b01;
  localparam logic [1:0] DATA  = 2'b10;
  localparam logic [1:0] STUFF = 2'b11;

  localparam logic [3:0] SYNC_PAT = 4'b1110;
  localparam int         SYNC_LEN = 4;

  localparam logic [1:0] MAX_RUN = 2'd2;

endpackage

// File: rtl/seq_frame_tx.sv
// Serial frame transmitter: sends the 1110 marker, then a DATA_W-bit payload
// MSB first, with a 0 stuffed after every pair of payload 1s.
module seq_frame_tx
  import seq_link_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter bit STUFF_EN = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid,
  input  logic [DATA_W-1:0] data_in,
  output logic              ready,
  output logic              seq_out,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  // state_q names the kind of bit currently on the line; counters already
  // account for that bit.
  logic [1:0]        state_q,    state_d;
  logic [DATA_W-1:0] shift_q,    shift_d;
  logic [CNT_W-1:0]  bit_cnt_q,  bit_cnt_d;
  logic [1:0]        sync_idx_q, sync_idx_d;
  logic [1:0]        ones_run_q, ones_run_d;
  logic              seq_out_q,  seq_out_d;
  logic              done_q,     done_d;

  logic              nxt_bit;
  logic [1:0]        nxt_run;
  logic [CNT_W-1:0]  nxt_cnt;
  logic              nxt_stuff;

  // Outcome of putting the next payload bit on the line.
  always_comb begin
    nxt_bit   = shift_q[DATA_W-1];
    nxt_run   = nxt_bit ? ones_run_q + 2'd1 : 2'd0;
    nxt_cnt   = bit_cnt_q - CNT_W'(1);
    nxt_stuff = STUFF_EN && (nxt_run == MAX_RUN);
  end

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    sync_idx_d = sync_idx_q;
    ones_run_d = ones_run_q;
    seq_out_d  = 1'b0;
    done_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (valid) begin
          state_d    = SYNC;
          seq_out_d  = SYNC_PAT[SYNC_LEN-1];
          shift_d    = data_in;
          bit_cnt_d  = CNT_W'(DATA_W);
          sync_idx_d = 2'd0;
          ones_run_d = 2'd0;
        end
      end

      SYNC: begin
        if (sync_idx_q == 2'(SYNC_LEN - 1)) begin
          state_d    = DATA;
          seq_out_d  = nxt_bit;
          shift_d    = shift_q << 1;
          bit_cnt_d  = nxt_cnt;
          ones_run_d = nxt_run;
          done_d     = (nxt_cnt == '0) && !nxt_stuff;
        end else begin
          sync_idx_d = sync_idx_q + 2'd1;
          seq_out_d  = SYNC_PAT[2'd3 - sync_idx_d];
        end
      end

      DATA: begin
        if (STUFF_EN && (ones_run_q == MAX_RUN)) begin
          state_d    = STUFF;
          ones_run_d = 2'd0;
          done_d     = (bit_cnt_q == '0);
        end else if (bit_cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          seq_out_d  = nxt_bit;
          shift_d    = shift_q << 1;
          bit_cnt_d  = nxt_cnt;
          ones_run_d = nxt_run;
          done_d     = (nxt_cnt == '0) && !nxt_stuff;
        end
      end

      STUFF: begin
        if (bit_cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          state_d    = DATA;
          seq_out_d  = nxt_bit;
          shift_d    = shift_q << 1;
          bit_cnt_d  = nxt_cnt;
          ones_run_d = nxt_run;
          done_d     = (nxt_cnt == '0) && !nxt_stuff;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all of them update together on the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      sync_idx_q <= 2'd0;
      ones_run_q <= 2'd0;
      seq_out_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      sync_idx_q <= sync_idx_d;
      ones_run_q <= ones_run_d;
      seq_out_q  <= seq_out_d;
      done_q     <= done_d;
    end
  end

  assign ready   = (state_q == IDLE);
  assign busy    = (state_q != IDLE);
  assign seq_out = seq_out_q;
  assign done    = done_q;

endmodule

// File: tb/tb_seq_frame_tx.sv
// Scoreboard bench for seq_frame_tx: expected frames are queued at issue time
// and compared by a monitor that also runs a 1110 detector on the line.
module tb_seq_frame_tx;

  typedef struct {
    logic [31:0] bits;
    int          len;
  } exp_t;

  logic       clk;
  logic       reset;
  logic       valid;
  logic [7:0] data_in;
  logic       ready;
  logic       seq_out;
  logic       busy;
  logic       done;

  int n_checks = 0;
  int n_fail   = 0;

  exp_t sb[$];
  int   gap_last = 0;

  seq_frame_tx #(.DATA_W(8), .STUFF_EN(1'b1)) dut (
    .clk     (clk),
    .reset   (reset),
    .valid   (valid),
    .data_in (data_in),
    .ready   (ready),
    .seq_out (seq_out),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] payload_line, input int payload_len);
    exp_t e;
    e.bits = (32'b1110 << payload_len) | payload_line;
    e.len  = 4 + payload_len;
    return e;
  endfunction

  // Reference stuffing: a 0 follows every second consecutive payload 1.
  function automatic exp_t frame_model(input logic [7:0] w);
    exp_t e;
    int run;
    run    = 0;
    e.bits = 32'b1110;
    e.len  = 4;
    for (int i = 7; i >= 0; i--) begin
      e.bits = {e.bits[30:0], w[i]};
      e.len++;
      run = w[i] ? run + 1 : 0;
      if (run == 2) begin
        e.bits = {e.bits[30:0], 1'b0};
        e.len++;
        run = 0;
      end
    end
    return e;
  endfunction

  // Monitor: collects each frame from busy rise to done, checks against the scoreboard.
  initial begin
    logic [3:0]  hist;
    logic [31:0] bits;
    logic        hit;
    logic        in_frame;
    logic        prev_done;
    int          cnt;
    int          hits;
    int          hit_pos;
    int          idle_cnt;
    exp_t        e;
    hist = '0; bits = '0; in_frame = 1'b0; prev_done = 1'b0;
    cnt = 0; hits = 0; hit_pos = -1; idle_cnt = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        hist = '0; in_frame = 1'b0; prev_done = 1'b0; cnt = 0; idle_cnt = 0;
      end else begin
        hist = {hist[2:0], seq_out};
        hit  = (hist == 4'b1110);
        check("busy_ready_excl", {31'd0, busy ^ ready}, 32'd1);
        if (prev_done) check("ready_after_done", {31'd0, ready}, 32'd1);
        if (!in_frame && busy) begin
          in_frame = 1'b1; cnt = 0; bits = '0; hits = 0; hit_pos = -1;
          gap_last = idle_cnt;
        end
        if (in_frame) begin
          bits = {bits[30:0], seq_out};
          cnt++;
          if (hit) begin
            hits++;
            hit_pos = cnt - 1;
          end
          if (done) begin
            in_frame = 1'b0;
            idle_cnt = 0;
            check("frame_expected", {31'd0, sb.size() > 0}, 32'd1);
            if (sb.size() > 0) begin
              e = sb.pop_front();
              check("frame_len", cnt, e.len);
              check("frame_bits", bits, e.bits);
              check("marker_count", hits, 1);
              check("marker_pos", hit_pos, 3);
            end
          end else if (cnt >= 32) begin
            check("done_missing", {31'd0, done}, 32'd1);
            in_frame = 1'b0;
          end
        end else begin
          check("idle_no_marker", {31'd0, hit}, 32'd0);
          check("idle_line_low", {31'd0, seq_out}, 32'd0);
          check("idle_no_done", {31'd0, done}, 32'd0);
          idle_cnt++;
        end
        prev_done = done;
      end
    end
  end

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (ready) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic send(input logic [7:0] w, input exp_t e, input bit push);
    bit ok;
    wait_ready(ok);
    if (!ok) begin
      check("ready_timeout", {31'd0, ready}, 32'd1);
      return;
    end
    if (push) sb.push_back(e);
    valid   = 1'b1;
    data_in = w;
    @(posedge clk);
    #1 valid = 1'b0;
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      #2;
      if (sb.size() == 0 && ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("drain_timeout", sb.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          ok;
    logic [7:0]  w;
    valid   = 1'b0;
    data_in = 8'h00;
    reset   = 1'b1;
    #22 reset = 1'b0;

    // Reset values after release.
    @(posedge clk); #2;
    check("rst_seq_out", {31'd0, seq_out}, 32'd0);
    check("rst_ready",   {31'd0, ready},   32'd1);
    check("rst_busy",    {31'd0, busy},    32'd0);
    check("rst_done",    {31'd0, done},    32'd0);

    // Reset asserted mid-idle takes effect without a clock edge.
    @(posedge clk); #3 reset = 1'b1;
    #1;
    check("idle_rst_outs", {28'd0, seq_out, ready, busy, done}, 32'b0100);
    #10 reset = 1'b0;

    // Reset asserted mid-frame aborts it immediately.
    send(8'hFF, frame_model(8'hFF), 1'b0);
    @(posedge clk);
    @(posedge clk); #2;
    check("pre_rst_busy", {31'd0, busy}, 32'd1);
    check("pre_rst_line", {31'd0, seq_out}, 32'd1);
    reset = 1'b1;
    #1;
    check("frame_rst_outs", {28'd0, seq_out, ready, busy, done}, 32'b0100);
    #10 reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("post_rst_quiet", {29'd0, seq_out, busy, ready}, 32'b001);
    end

    // Directed payloads with hand-stuffed line images.
    send(8'hA5, mk(32'b10100101, 8), 1'b1);
    drain();
    send(8'hFF, mk(32'b110110110110, 12), 1'b1);
    drain();
    send(8'h6E, mk(32'b0110011010, 10), 1'b1);
    drain();

    // Back-to-back with valid held; a stray pulse during frame 1 is ignored.
    wait_ready(ok);
    check("b2b_ready", {31'd0, ready}, 32'd1);
    sb.push_back(mk(32'b0011011000, 10));
    valid = 1'b1; data_in = 8'h3C;
    @(posedge clk); #1 valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 valid = 1'b1; data_in = 8'h00;
    @(posedge clk); #1 valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 valid = 1'b1; data_in = 8'hC3;
    sb.push_back(mk(32'b1100000110, 10));
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (ready) begin
        ok = 1'b1;
        break;
      end
    end
    check("b2b_accept", {31'd0, ok}, 32'd1);
    @(posedge clk); #1 valid = 1'b0;
    drain();
    check("b2b_gap", gap_last, 1);

    // Loopback through the line detector with random payloads.
    for (int i = 0; i < 256; i++) begin
      w = 8'($urandom_range(0, 255));
      send(w, frame_model(w), 1'b1);
    end
    drain();
    check("sb_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
